frame_reader: RTL
=================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WORDS, default 512: words per half-buffer; the RAM holds 2*WORDS words of 12 bits.
REQ-002 Parameter RAM_LAT, default 2: clocks from rdAddr change to valid rdData.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; high = stream frames, low = stop at next word boundary.
REQ-006 bitTick  input  1  one-clock strobe per output bit; successive strobes are at least RAM_LAT+2 clocks apart.
REQ-007 rdData  input  12  RAM read-port data for the current rdAddr.
REQ-008 rdAddr  output  10  RAM read address = {rdHalf, wordIdx[8:0]}.
REQ-009 bufSwitch  output  1  half the writer fills; the reader always reads half ~bufSwitch.
REQ-010 serialOut  output  1  serial data, MSB first, 12 bits per word.
REQ-011 wordStrobe  output  1  one-clock pulse when bit 11 of any word is driven onto serialOut.
REQ-012 frameStart  output  1  one-clock pulse when bit 11 of word 0 of a half is driven.

Function
REQ-013 The FSM SHALL have states IDLE, PRIME, STREAM and DRAIN.
REQ-014 IDLE -> PRIME when enable=1: rdAddr={~bufSwitch, 0}; after RAM_LAT clocks, rdData loads the shift register, bitCnt=0, state -> STREAM.
REQ-015 On loading a word into the shift register, rdAddr SHALL advance to the next word, and rdData SHALL be captured into a prefetch register RAM_LAT clocks later.
REQ-016 In STREAM, each bitTick SHALL drive serialOut with shift[11], shift left by one bit, and increment bitCnt.
REQ-017 A bitTick with bitCnt=11 SHALL transfer the prefetch register into the shift register, clear bitCnt, and increment wordIdx, so there is no gap between words.
REQ-018 Between bitTicks, serialOut SHALL hold its last value.
REQ-019 wordStrobe and frameStart SHALL assert in the clock after the bitTick that drives bit 11.
REQ-020 Wrap: on completion of word WORDS-1, bufSwitch SHALL toggle, wordIdx SHALL go to 0, and the prefetch SHALL read the newly released half.
REQ-021 The prefetch for index 0 of the new half SHALL issue only after bufSwitch has toggled.
REQ-022 If enable=0 at a word boundary (the bitCnt=11 tick), the FSM SHALL enter DRAIN, which holds serialOut until the next bitTick, then drives 0 and goes to IDLE.
REQ-023 On entering IDLE, wordIdx SHALL clear to 0 and bufSwitch SHALL be unchanged.
REQ-024 If enable is deasserted mid-word, the current word SHALL complete.
REQ-025 If enable is reasserted during DRAIN, the FSM SHALL still pass through IDLE before streaming.
REQ-026 A bitTick during PRIME SHALL be ignored.
REQ-027 wordIdx SHALL be 9 bits and SHALL wrap at WORDS-1, never at 511 unless WORDS=512.
REQ-028 rdAddr SHALL change only on a load or a wrap, never on a plain bitTick.

Reset
REQ-029 While reset=0, outputs SHALL be: serialOut=0, wordStrobe=0, frameStart=0, bufSwitch=0, rdAddr=10'h200; internally, state=IDLE, bitCnt=0, wordIdx=0, shift and prefetch registers = 0.
REQ-030 Reset assertion mid-STREAM SHALL take effect asynchronously, with no partial word emitted afterward.
REQ-031 After reset release, the first frame SHALL start only through IDLE -> PRIME.

Verification
REQ-032 Preload RAM[512]=12'hF9A, RAM[513]=12'h5A5; enable=1, bitTick every 8 clocks -> serialOut 1111_1001_1010_0101_1010_0101, frameStart with the first bit, wordStrobe at bits 1 and 13, with no idle tick between words.
REQ-033 WORDS=4: stream 4 words -> bufSwitch toggles 0->1 after the 48th tick; rdAddr goes to 10'h000; the next word comes from RAM[0] with frameStart.
REQ-034 Drop enable at tick 5 of word 2 -> word 2 completes (12 bits); serialOut=0 after one more tick; state IDLE; re-enable restarts at RAM[512] of the same half.
REQ-035 Assert reset at tick 7 of a word -> all outputs at reset values immediately; after release with enable=1 -> first bits come from RAM[512].
REQ-036 bitTick pulses during PRIME -> no bits emitted; the first emitted bit is shift[11] of the primed word.
REQ-037 Run 3 full halves with WORDS=512 against a reference model -> bit-exact stream, bufSwitch toggling every 6144 ticks, and no rdAddr change except on loads and wraps.

Source files
------------

// File: rtl/frame_reader.sv
// Serialises 12-bit words from the read half of a double-buffered frame RAM,
// MSB first, one bit per bitTick, with the next word prefetched so that
// consecutive words leave no idle tick between them.
module frame_reader #(
  parameter int unsigned WORDS   = 512,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        bitTick,
  input  logic [11:0] rdData,
  output logic [9:0]  rdAddr,
  output logic        bufSwitch,
  output logic        serialOut,
  output logic        wordStrobe,
  output logic        frameStart
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  localparam logic [8:0]       LAST_IDX = 9'(WORDS - 1);
  localparam logic [3:0]       LAST_BIT = 4'd11;
  localparam int unsigned      LW       = $clog2(RAM_LAT + 1) + 1;
  localparam logic [LW-1:0]    LAT_END  = LW'(RAM_LAT);

  state_t        state, stateNxt;
  logic [11:0]   shiftReg;
  logic [11:0]   prefetch;
  logic [3:0]    bitCnt;
  logic [8:0]    wordIdx;
  logic [LW-1:0] latCnt;
  logic          rdPend;
  logic          rdToShift;

  logic          fillBusy;
  logic          rdLand;
  logic          tickAct;
  logic          wordEnd;

  // One outstanding RAM read at a time: rdToShift selects whether the returning
  // word goes straight into the shifter (prime / new half) or into prefetch.
  // The read for index 0 of a new half is only issued once bufSwitch has
  // toggled, so that word lands directly in the shifter before the next tick.
  always_comb begin
    fillBusy = rdPend && rdToShift;
    rdLand   = rdPend && (latCnt == LAT_END);
    tickAct  = bitTick && (state == STREAM) && !fillBusy;
    wordEnd  = tickAct && (bitCnt == LAST_BIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (enable) stateNxt = PRIME;
      PRIME:   if (rdLand && rdToShift) stateNxt = STREAM;
      STREAM:  if (wordEnd && !enable) stateNxt = DRAIN;
      DRAIN:   if (bitTick) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdAddr     <= 10'h200;
      bufSwitch  <= 1'b0;
      serialOut  <= 1'b0;
      wordStrobe <= 1'b0;
      frameStart <= 1'b0;
      shiftReg   <= '0;
      prefetch   <= '0;
      bitCnt     <= '0;
      wordIdx    <= '0;
      latCnt     <= '0;
      rdPend     <= 1'b0;
      rdToShift  <= 1'b0;
    end else begin
      wordStrobe <= 1'b0;
      frameStart <= 1'b0;

      if (rdPend) begin
        if (latCnt == LAT_END) begin
          rdPend <= 1'b0;
          if (rdToShift) begin
            shiftReg <= rdData;
            bitCnt   <= '0;
            if (wordIdx != LAST_IDX) begin
              rdAddr    <= {~bufSwitch, wordIdx + 9'd1};
              rdPend    <= 1'b1;
              rdToShift <= 1'b0;
              latCnt    <= '0;
            end
          end else begin
            prefetch <= rdData;
          end
        end else begin
          latCnt <= latCnt + LW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (enable) begin
            rdAddr    <= {~bufSwitch, 9'd0};
            wordIdx   <= '0;
            bitCnt    <= '0;
            rdPend    <= 1'b1;
            rdToShift <= 1'b1;
            latCnt    <= '0;
          end
        end
        STREAM: begin
          if (tickAct) begin
            serialOut  <= shiftReg[11];
            wordStrobe <= (bitCnt == 4'd0);
            frameStart <= (bitCnt == 4'd0) && (wordIdx == 9'd0);
            if (bitCnt != LAST_BIT) begin
              shiftReg <= {shiftReg[10:0], 1'b0};
              bitCnt   <= bitCnt + 4'd1;
            end else begin
              bitCnt <= '0;
              if (wordIdx == LAST_IDX) begin
                bufSwitch <= ~bufSwitch;
                wordIdx   <= '0;
                if (enable) begin
                  rdAddr    <= {bufSwitch, 9'd0};
                  rdPend    <= 1'b1;
                  rdToShift <= 1'b1;
                  latCnt    <= '0;
                end
              end else if (enable) begin
                shiftReg <= prefetch;
                wordIdx  <= wordIdx + 9'd1;
                if ((wordIdx + 9'd1) != LAST_IDX) begin
                  rdAddr    <= {~bufSwitch, wordIdx + 9'd2};
                  rdPend    <= 1'b1;
                  rdToShift <= 1'b0;
                  latCnt    <= '0;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (bitTick) begin
            serialOut <= 1'b0;
            wordIdx   <= '0;
            bitCnt    <= '0;
            rdPend    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
